// File: rtl/inner_wb_arbiter.sv
// Round-robin arbiter sharing the inner Wishbone bus between dcache (port 0) and two icaches.
// Grant is held for a whole CYC; a stall watchdog aborts a hung owner with ERR.
module inner_wb_arbiter #(
    parameter int WB_ADDR_W   = 24,
    parameter int WB_DATA_W   = 16,
    parameter int WB_SEL_BITS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [2:0]               m_cyc,
    input  logic [2:0]               m_stb,
    input  logic [2:0]               m_we,
    input  logic [3*WB_ADDR_W-1:0]   m_adr,
    input  logic [3*WB_DATA_W-1:0]   m_o_dat,
    input  logic [3*WB_SEL_BITS-1:0] m_sel,
    input  logic [2:0]               m_4_burst,
    input  logic [2:0]               m_8_burst,
    output logic [WB_DATA_W-1:0]     m_i_dat,
    output logic [2:0]               m_ack,
    output logic [2:0]               m_err,
    output logic                     s_cyc,
    output logic                     s_stb,
    output logic                     s_we,
    output logic [WB_ADDR_W-1:0]     s_adr,
    output logic [WB_DATA_W-1:0]     s_o_dat,
    output logic [WB_SEL_BITS-1:0]   s_sel,
    output logic                     s_4_burst,
    output logic                     s_8_burst,
    input  logic [WB_DATA_W-1:0]     s_i_dat,
    input  logic                     s_ack,
    input  logic                     s_err,
    output logic [1:0]               o_owner,
    output logic                     o_timeout
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t           state_q;
    logic [1:0]       owner_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] cnt_q;

    logic                   own_cyc, own_stb, own_we, own_b4, own_b8;
    logic [WB_ADDR_W-1:0]   own_adr;
    logic [WB_DATA_W-1:0]   own_dat;
    logic [WB_SEL_BITS-1:0] own_sel;
    logic [1:0]             grant;
    logic [2:0]             own_oh;
    logic                   in_own, stall, abort, live;

    // First requester after the last winner, in cyclic order.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        int         idx;
        pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_b4  = 1'b0;
        own_b8  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int i = 0; i < 3; i++) begin
            if (owner_q == 2'(i)) begin
                own_cyc = m_cyc[i];
                own_stb = m_stb[i];
                own_we  = m_we[i];
                own_b4  = m_4_burst[i];
                own_b8  = m_8_burst[i];
                own_adr = m_adr[i*WB_ADDR_W +: WB_ADDR_W];
                own_dat = m_o_dat[i*WB_DATA_W +: WB_DATA_W];
                own_sel = m_sel[i*WB_SEL_BITS +: WB_SEL_BITS];
            end
        end
    end

    assign grant  = rr_pick(m_cyc, last_q);
    assign in_own = (state_q == OWN);
    assign stall  = in_own && own_cyc && own_stb && !s_ack && !s_err;
    // An ACK/ERR in the would-be timeout cycle clears stall, so the slave response wins.
    assign abort  = (TIMEOUT != 0) && stall && (cnt_q == TO_M1);
    assign live   = in_own && own_cyc && !abort;
    assign own_oh = in_own ? (3'b001 << owner_q) : 3'b000;

    assign s_cyc     = live;
    assign s_stb     = live && own_stb;
    assign s_we      = live && own_we;
    assign s_4_burst = live && own_b4;
    assign s_8_burst = live && own_b8;
    assign s_adr     = own_adr;
    assign s_o_dat   = own_dat;
    assign s_sel     = own_sel;

    assign m_i_dat   = s_i_dat;
    assign m_ack     = i_rst ? 3'b000 : (own_oh & {3{s_ack}});
    assign m_err     = i_rst ? 3'b000 : (own_oh & {3{s_err | abort}});
    assign o_timeout = abort && !i_rst;
    assign o_owner   = owner_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|m_cyc) begin
                        owner_q <= grant;
                        last_q  <= grant;
                        cnt_q   <= '0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    if (abort) begin
                        state_q <= ABORT;
                    end else if (!own_cyc) begin
                        state_q <= IDLE;
                        owner_q <= 2'd3;
                    end else if (s_ack || s_err) begin
                        cnt_q <= '0;
                    end else if (stall && cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ABORT: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        owner_q <= 2'd3;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= 2'd3;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inner_wb_arbiter.sv
// Scoreboard bench for inner_wb_arbiter: driver pushes expected grants/responses from a
// round-robin reference model, a negedge monitor pops and compares them.
module tb_inner_wb_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        m_cyc, m_stb, m_we, m_4_burst, m_8_burst;
    logic [3*AW-1:0]   m_adr;
    logic [3*DW-1:0]   m_o_dat;
    logic [3*SW-1:0]   m_sel;
    logic [DW-1:0]     m_i_dat;
    logic [2:0]        m_ack, m_err;
    logic              s_cyc, s_stb, s_we, s_4_burst, s_8_burst;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_o_dat;
    logic [SW-1:0]     s_sel;
    logic [DW-1:0]     s_i_dat;
    logic              s_ack, s_err;
    logic [1:0]        o_owner;
    logic              o_timeout;

    always #5 clk = ~clk;

    inner_wb_arbiter #(.WB_ADDR_W(AW), .WB_DATA_W(DW), .WB_SEL_BITS(SW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_o_dat(m_o_dat),
        .m_sel(m_sel), .m_4_burst(m_4_burst), .m_8_burst(m_8_burst),
        .m_i_dat(m_i_dat), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_o_dat(s_o_dat),
        .s_sel(s_sel), .s_4_burst(s_4_burst), .s_8_burst(s_8_burst),
        .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err),
        .o_owner(o_owner), .o_timeout(o_timeout)
    );

    typedef struct {
        logic [2:0]    ack;
        logic [2:0]    err;
        logic          tmo;
        logic          scyc;
        logic [DW-1:0] dat;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic [SW-1:0] sel;
        logic          we;
        logic          b4;
        logic          b8;
    } rsp_t;

    typedef struct {
        int owner;
        int gap;
    } gnt_t;

    rsp_t rsp_q[$];
    gnt_t gnt_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [AW-1:0] ma[3];
    logic [DW-1:0] md[3];
    logic [SW-1:0] ms[3];
    logic          mw[3], h4[3], h8[3];
    int            mlast;
    int            fixed_delay = -1, fixed_rdat = -1, fixed_beats = -1;
    bit            mon_en = 1'b0;
    int            prev_owner = 3, idle_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic rand_master(input int i);
        int r;
        ma[i] = AW'($urandom());
        md[i] = DW'($urandom());
        ms[i] = SW'($urandom());
        mw[i] = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 3);
        h4[i] = (r == 1);
        h8[i] = (r == 2);
    endtask

    task automatic drive_master(input int i, input logic on);
        m_cyc[i] = on;
        m_stb[i] = on;
        m_we[i] = mw[i];
        m_4_burst[i] = h4[i];
        m_8_burst[i] = h8[i];
        m_adr[i*AW +: AW] = ma[i];
        m_o_dat[i*DW +: DW] = md[i];
        m_sel[i*SW +: SW] = ms[i];
    endtask

    task automatic push_rsp(input logic [2:0] ack, input logic [2:0] err, input logic tmo,
                            input logic scyc, input logic [DW-1:0] dat, input int w);
        rsp_t e;
        e.ack = ack; e.err = err; e.tmo = tmo; e.scyc = scyc; e.dat = dat;
        e.adr = ma[w]; e.wdat = md[w]; e.sel = ms[w]; e.we = mw[w]; e.b4 = h4[w]; e.b8 = h8[w];
        rsp_q.push_back(e);
    endtask

    task automatic push_gnt(input int w, input int gap);
        gnt_t g;
        g.owner = w;
        g.gap = gap;
        gnt_q.push_back(g);
    endtask

    // Serve requesters in round-robin order; persist makes served masters re-request at once.
    task automatic run_round(input logic [2:0] req, input int ngr, input bit persist,
                             input int late_m, input int late_beat);
        logic [2:0]    pend;
        logic [DW-1:0] rd;
        int            w, nb, d;
        bit            last, late_done;
        pend = req;
        late_done = 1'b0;
        for (int i = 0; i < 3; i++) if (req[i]) drive_master(i, 1'b1);
        tick();
        for (int g = 0; g < ngr && pend != 3'b000; g++) begin
            w = rr_pick(pend, mlast);
            mlast = w;
            push_gnt(w, (g == 0) ? -1 : 1);
            chk("grant_latency", 32'(s_cyc), 32'd1);
            nb = (fixed_beats > 0) ? fixed_beats : h8[w] ? 8 : h4[w] ? 4 : $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if (late_m >= 0 && !late_done && b == late_beat && w != late_m) begin
                    drive_master(late_m, 1'b1);
                    pend[late_m] = 1'b1;
                    late_done = 1'b1;
                end
                d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                repeat (d) tick();
                rd = (fixed_rdat >= 0) ? DW'(fixed_rdat) : DW'($urandom());
                s_ack = 1'b1;
                s_i_dat = rd;
                push_rsp(3'(1 << w), 3'b000, 1'b0, 1'b1, rd, w);
                tick();
                s_ack = 1'b0;
            end
            last = (g == ngr - 1);
            if (last) for (int i = 0; i < 3; i++) drive_master(i, 1'b0);
            else drive_master(w, 1'b0);
            tick();
            if (last) pend = 3'b000;
            else if (!persist) pend[w] = 1'b0;
            else drive_master(w, 1'b1);
            if (pend != 3'b000) tick();
        end
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        rsp_t e;
        gnt_t g;
        if (mon_en) begin
            if (m_ack != 3'b000 || m_err != 3'b000 || o_timeout) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'({m_ack, m_err, o_timeout}), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("m_ack", 32'(m_ack), 32'(e.ack));
                    chk("m_err", 32'(m_err), 32'(e.err));
                    chk("o_timeout", 32'(o_timeout), 32'(e.tmo));
                    chk("s_cyc_at_rsp", 32'(s_cyc), 32'(e.scyc));
                    if (e.ack != 3'b000) begin
                        chk("m_i_dat", 32'(m_i_dat), 32'(e.dat));
                        chk("s_adr", 32'(s_adr), 32'(e.adr));
                        chk("s_o_dat", 32'(s_o_dat), 32'(e.wdat));
                        chk("s_sel", 32'(s_sel), 32'(e.sel));
                        chk("s_we", 32'(s_we), 32'(e.we));
                        chk("s_4_burst", 32'(s_4_burst), 32'(e.b4));
                        chk("s_8_burst", 32'(s_8_burst), 32'(e.b8));
                    end
                end
            end
            if (o_owner != 2'd3 && int'(o_owner) != prev_owner) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", 32'(o_owner), 32'd3);
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant_owner", 32'(o_owner), 32'(g.owner));
                    if (g.gap >= 0) chk("idle_gap", 32'(idle_run), 32'(g.gap));
                end
            end
            if (o_owner == 2'd3) idle_run++;
            else idle_run = 0;
            prev_owner = int'(o_owner);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_4_burst = '0; m_8_burst = '0;
        m_adr = '0; m_o_dat = '0; m_sel = '0;
        s_i_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        for (int i = 0; i < 3; i++) rand_master(i);
        repeat (3) tick();
        chk("rst_owner", 32'(o_owner), 32'd3);
        chk("rst_ctrl", 32'({s_cyc, s_stb, s_we, s_4_burst, s_8_burst}), 32'd0);
        chk("rst_resp", 32'({m_ack, m_err, o_timeout}), 32'd0);
        rst = 1'b0;
        mlast = 2;
        mon_en = 1'b1;
        tick();

        // Master 1 read of 0x001234, ACK on the third owned cycle with 0xBEEF.
        rand_master(1);
        ma[1] = 24'h001234; mw[1] = 1'b0; h4[1] = 1'b0; h8[1] = 1'b0;
        fixed_delay = 2; fixed_rdat = 16'hBEEF; fixed_beats = 1;
        run_round(3'b010, 99, 1'b0, -1, 0);
        fixed_delay = -1; fixed_rdat = -1; fixed_beats = -1;

        // Random request sets and slave timings.
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < 3; i++) rand_master(i);
            run_round(3'($urandom_range(1, 7)), 99, 1'b0, -1, 0);
        end
        for (int i = 0; i < 3; i++) rand_master(i);
        run_round(3'($urandom_range(1, 7)), 5, 1'b1, -1, 0);

        // 8-beat burst from master 0, master 2 joins on beat 2.
        rand_master(0); rand_master(2);
        h8[0] = 1'b1; h4[0] = 1'b0;
        run_round(3'b001, 99, 1'b0, 2, 2);

        // Watchdog abort on master 2, late ACK must be dropped.
        rand_master(2);
        drive_master(2, 1'b1);
        w = rr_pick(3'b100, mlast);
        mlast = w;
        push_gnt(w, -1);
        tick();
        chk("to_grant_s_cyc", 32'(s_cyc), 32'd1);
        push_rsp(3'b000, 3'b100, 1'b1, 1'b0, '0, 2);
        repeat (3) tick();
        chk("abort_cycle_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        chk("abort_hold_ctrl", 32'({s_cyc, s_stb}), 32'd0);
        s_ack = 1'b1;
        s_i_dat = 16'h1111;
        tick();
        s_ack = 1'b0;
        drive_master(2, 1'b0);
        tick();
        tick();
        chk("abort_to_idle_owner", 32'(o_owner), 32'd3);
        tick();

        // ACK lands exactly on the cycle the stall count would reach TIMEOUT.
        rand_master(1);
        h4[1] = 1'b0; h8[1] = 1'b0;
        fixed_delay = TO - 1; fixed_beats = 2;
        run_round(3'b010, 99, 1'b0, -1, 0);
        fixed_delay = -1; fixed_beats = -1;

        // Reset in the middle of a master 1 transfer, then all three compete.
        for (int i = 0; i < 3; i++) rand_master(i);
        drive_master(1, 1'b1);
        w = rr_pick(3'b010, mlast);
        mlast = w;
        push_gnt(w, -1);
        tick();
        chk("pre_rst_s_cyc", 32'(s_cyc), 32'd1);
        tick();
        rst = 1'b1;
        drive_master(0, 1'b1);
        drive_master(2, 1'b1);
        tick();
        rst = 1'b0;
        mlast = 2;
        chk("post_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("post_rst_owner", 32'(o_owner), 32'd3);
        run_round(3'b111, 4, 1'b1, -1, 0);

        repeat (5) tick();
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
